imem_byte_loader: RTL and testbench
===================================

# imem_byte_loader

Receiving end of the CPU's byte-serial program-load interface. Accepts instruction bytes on `instr_i`, assembles them little-endian into 32-bit words, and writes them sequentially into instruction memory from word 0. Holds the CPU core in reset until the image is complete. Sits between the top-level `instr_i` pin and the IMEM write port inside `RISC_V_CPU`.

## Interface
- `NUM_WORDS`, 64: words per program image; the image is NUM_WORDS*4 bytes.
- `AW`, 6: IMEM word-address width, clog2(NUM_WORDS).

- `sys_clk` in 1: sole clock; all state changes on its rising edge.
- `sys_reset_n` in 1: synchronous, active-low reset.
- `instr_i` in 8: program byte, sampled when `byte_valid_i`=1.
- `byte_valid_i` in 1: byte qualifier; the top level ties it to 1 for free-running one-byte-per-cycle load.
- `reload_i` in 1: one-cycle request to restart loading from word 0. Honoured only in DONE.
- `imem_we_o` out 1: IMEM write strobe, one-cycle pulse per word.
- `imem_addr_o` out AW: IMEM word address.
- `imem_wdata_o` out 32: assembled instruction word.
- `load_done_o` out 1: image complete.
- `core_reset_o` out 1: active-high reset to the CPU core; equals ~`load_done_o`.
- `byte_cnt_o` out AW+2: bytes accepted in the current load (debug).

## Operation
- States: LOAD, DONE. Reset enters LOAD.
- Byte lane: `byte_sel` (2 bit) selects the lane for the next byte; byte k of a word goes to bits [8k+7:8k]. The first byte of the stream goes to word 0, bits [7:0].
- In LOAD, with `byte_valid_i`=1: the byte is stored in lane `byte_sel`, `byte_sel` increments, and `byte_cnt_o` increments.
- When `byte_sel`=3 and a byte is accepted:
  - The full word (the three stored bytes plus the current byte) is registered onto `imem_wdata_o`.
  - `imem_addr_o` takes `word_ptr`, `imem_we_o`=1 for the next cycle, and `word_ptr` increments.
- Last word: when `word_ptr`=NUM_WORDS-1 and the 4th byte is accepted, the write is issued as above and the state goes to DONE on the same edge.
- DONE:
  - Bytes are ignored, whatever `byte_valid_i` is; extra stream bytes, such as byte 256 of a 257-byte stream, have no effect.
  - `load_done_o`=1 and `core_reset_o`=0.
- `reload_i`=1 in DONE:
  - Next edge: state goes to LOAD; `byte_sel`, `word_ptr` and `byte_cnt_o` clear to 0; `load_done_o` goes to 0.
  - IMEM contents are left alone; they are overwritten as new words arrive.
- `reload_i` in LOAD is ignored.
- `byte_valid_i`=0 in LOAD freezes all state; a partial word is kept.
- `word_ptr` never wraps within a load; it stops at NUM_WORDS-1 because the state leaves LOAD.
- `imem_wdata_o` and `imem_addr_o` hold their last values while `imem_we_o`=0.

## Timing
- Reset (`sys_reset_n`=0 at an edge), values after that edge:
  - state LOAD; `imem_we_o`=0, `imem_addr_o`=0, `imem_wdata_o`=0;
  - `load_done_o`=0, `core_reset_o`=1, `byte_cnt_o`=0, `byte_sel`=0, `word_ptr`=0.
- Reset has priority over every other input, including in the middle of a word or a load; the partial word is discarded.
- Latency: if the 4th byte of a word is accepted at edge N:
  - `imem_we_o`, `imem_addr_o` and `imem_wdata_o` are valid in the cycle after N;
  - `imem_we_o` returns to 0 at edge N+1 unless another word completes at N+1, which cannot happen (at least 4 edges separate words).
- Done: with the final 4th byte accepted at edge N, `load_done_o`=1 and `core_reset_o`=0 from edge N. The final write pulse is also in cycle N to N+1, so the core leaves reset in the same cycle as the final IMEM write and fetches on edge N+1 or later.
- Free-running load: 4*NUM_WORDS cycles from the first valid edge to `load_done_o`, i.e. 256 cycles at the default NUM_WORDS.
- Simultaneous events:
  - `reload_i` with `sys_reset_n`=0: reset wins.
  - `reload_i` with `byte_valid_i` in DONE: the byte is dropped; the first byte accepted is on the next edge.

## Test plan
- Reset, then free-run bytes 0x13,0x05,0x50,0x00 (`addi x10,x0,5`) → IMEM word 0 = 0x00500513, `imem_we_o` high exactly 1 cycle, one cycle after the 4th byte edge.
- Full 256-byte stream with byte k = k[7:0] → 64 write pulses; word i = {4i+3, 4i+2, 4i+1, 4i}; `load_done_o` rises at edge 256; `core_reset_o` falls on the same edge; byte 257 (0xFF) is ignored.
- `byte_valid_i` low for 3 cycles after byte 2 of word 5 → word 5 is still correct; `byte_cnt_o` holds at 22 during the gap.
- `sys_reset_n`=0 after 130 bytes → all outputs at reset values; restart from 0 gives the correct image with word 0 rewritten.
- In DONE, pulse `reload_i` and then stream 0xAA×256 → `load_done_o` low for 256 cycles; all words = 0xAAAAAAAA.
- `reload_i` pulsed mid-LOAD at byte 40 → no effect; `load_done_o` rises at byte 256 as normal.

Source files
------------

// File: rtl/imem_byte_loader.sv
// Byte-serial program loader: packs little-endian bytes into 32-bit IMEM words and holds the core in reset until the image is complete.
// Each completed word is written one cycle after its 4th byte; byte_valid_i=0 stalls the load with all state held.
module imem_byte_loader #(
  parameter int NUM_WORDS = 64,
  parameter int AW        = 6
) (
  input  logic          sys_clk,
  input  logic          sys_reset_n,
  input  logic [7:0]    instr_i,
  input  logic          byte_valid_i,
  input  logic          reload_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          load_done_o,
  output logic          core_reset_o,
  output logic [AW+1:0] byte_cnt_o
);

  typedef enum logic {LOAD, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    byte_sel;
  logic [AW-1:0] word_ptr;
  logic [23:0]   lanes;
  logic          accept;
  logic          word_done;
  logic          last_word;
  logic          reload_go;

  always_comb begin
    accept    = 1'b0;
    word_done = 1'b0;
    last_word = 1'b0;
    reload_go = 1'b0;
    state_nxt = state;
    case (state)
      LOAD: begin
        accept    = byte_valid_i;
        word_done = accept && (byte_sel == 2'd3);
        last_word = word_done && (word_ptr == AW'(NUM_WORDS - 1));
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        reload_go = reload_i;
        if (reload_i) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state        <= LOAD;
      byte_sel     <= 2'd0;
      word_ptr     <= '0;
      byte_cnt_o   <= '0;
      lanes        <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
    end else begin
      state     <= state_nxt;
      imem_we_o <= word_done;
      if (accept) begin
        byte_sel   <= byte_sel + 2'd1;
        byte_cnt_o <= byte_cnt_o + 1'b1;
        case (byte_sel)
          2'd0:    lanes[7:0]   <= instr_i;
          2'd1:    lanes[15:8]  <= instr_i;
          2'd2:    lanes[23:16] <= instr_i;
          default: ;
        endcase
      end
      if (word_done) begin
        imem_wdata_o <= {instr_i, lanes};
        imem_addr_o  <= word_ptr;
        // Pointer parks on the last word; leaving LOAD ends the image instead of wrapping.
        if (!last_word) word_ptr <= word_ptr + 1'b1;
      end
      if (reload_go) begin
        byte_sel   <= 2'd0;
        word_ptr   <= '0;
        byte_cnt_o <= '0;
      end
    end
  end

  assign load_done_o  = (state == DONE);
  assign core_reset_o = ~load_done_o;

endmodule

// File: tb/tb_imem_byte_loader.sv
// Scoreboard bench for imem_byte_loader: drivers push expected IMEM writes, a negedge monitor pops and compares them.
module tb_imem_byte_loader;

  logic       sys_clk      = 1'b0;
  logic       sys_reset_n  = 1'b0;
  logic [7:0] instr_i      = 8'h00;
  logic       byte_valid_i = 1'b0;
  logic       reload_i     = 1'b0;
  logic       imem_we_o;
  logic [5:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic       load_done_o;
  logic       core_reset_o;
  logic [7:0] byte_cnt_o;

  imem_byte_loader #(.NUM_WORDS(64), .AW(6)) dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .instr_i      (instr_i),
    .byte_valid_i (byte_valid_i),
    .reload_i     (reload_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .load_done_o  (load_done_o),
    .core_reset_o (core_reset_o),
    .byte_cnt_o   (byte_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  int  nwr    = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  initial begin
    wr_t  e;
    logic prev_we;
    prev_we = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_reset_n && imem_we_o) begin
        nwr++;
        check("we_single_cycle", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %h, expected no write", imem_addr_o, imem_wdata_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {26'd0, imem_addr_o}, {26'd0, e.addr});
          check("wr_data", imem_wdata_o, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      prev_we = imem_we_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] b, input logic v, input logic rl);
    @(negedge sys_clk);
    instr_i      = b;
    byte_valid_i = v;
    reload_i     = rl;
  endtask

  task automatic push_exp(input int word, input logic [31:0] data);
    wr_t e;
    e.addr = 6'(word);
    e.data = data;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Reset asserted together with a valid byte and a reload: reset must win.
  task automatic do_reset();
    @(negedge sys_clk);
    sys_reset_n  = 1'b0;
    byte_valid_i = 1'b1;
    reload_i     = 1'b1;
    instr_i      = 8'h77;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_reset_n  = 1'b1;
    byte_valid_i = 1'b0;
    reload_i     = 1'b0;
    check("rst_we",        {31'd0, imem_we_o},    32'd0);
    check("rst_addr",      {26'd0, imem_addr_o},  32'd0);
    check("rst_wdata",     imem_wdata_o,          32'd0);
    check("rst_done",      {31'd0, load_done_o},  32'd0);
    check("rst_core_rst",  {31'd0, core_reset_o}, 32'd1);
    check("rst_byte_cnt",  {24'd0, byte_cnt_o},   32'd0);
  endtask

  // Streams n bytes: pattern k[7:0] or 0xAA; optional 3-cycle gap and mid-load reload pulse.
  task automatic load_bytes(input bit aa, input int n, input int gap_after, input int reload_at);
    logic [7:0]  b;
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      b = aa ? 8'hAA : 8'(k);
      drive(b, 1'b1, k == reload_at);
      if (k == 0) begin
        check("load_start_done", {31'd0, load_done_o}, 32'd0);
        check("load_start_cnt",  {24'd0, byte_cnt_o},  32'd0);
      end
      if (k == 1)   check("first_byte_cnt", {24'd0, byte_cnt_o}, 32'd1);
      if (k == 128) check("mid_load_done",  {31'd0, load_done_o}, 32'd0);
      if (k == 255) check("done_before_last", {31'd0, load_done_o}, 32'd0);
      if (k % 4 == 3) begin
        w = aa ? 32'hAAAA_AAAA : {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
        push_exp(k / 4, w);
      end
      if (k == gap_after) begin
        for (int g = 0; g < 3; g++) begin
          drive(8'h5A, 1'b0, 1'b0);
          check("gap_byte_cnt", {24'd0, byte_cnt_o}, 32'(k + 1));
        end
      end
    end
    drive(8'h00, 1'b0, 1'b0);
    if (n == 256) begin
      check("done_at_edge_256", {31'd0, load_done_o},  32'd1);
      check("core_rst_low",     {31'd0, core_reset_o}, 32'd0);
    end
  endtask

  initial begin
    int start;

    do_reset();

    // addi x10,x0,5
    drive(8'h13, 1'b1, 1'b0);
    drive(8'h05, 1'b1, 1'b0);
    drive(8'h50, 1'b1, 1'b0);
    drive(8'h00, 1'b1, 1'b0);
    push_exp(0, 32'h0050_0513);
    repeat (4) drive(8'h00, 1'b0, 1'b0);

    do_reset();

    // Full image, then a stray 257th byte.
    start = nwr;
    load_bytes(1'b0, 256, -1, -1);
    drive(8'hFF, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    check("done_after_extra", {31'd0, load_done_o}, 32'd1);
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    check("write_count", nwr - start, 32'd64);

    // Reload with a simultaneous byte (dropped); gap inside word 5; reload ignored mid-load.
    drive(8'hEE, 1'b1, 1'b1);
    load_bytes(1'b0, 256, 21, 40);

    drive(8'hEE, 1'b1, 1'b1);
    load_bytes(1'b1, 256, -1, -1);

    // Reset part-way through a load, then a full reload from word 0.
    drive(8'h00, 1'b0, 1'b1);
    load_bytes(1'b0, 130, -1, -1);
    do_reset();
    load_bytes(1'b0, 256, -1, -1);

    repeat (3) drive(8'h00, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
